pattern_scheduler: RTL
======================

// Module: pattern_scheduler
// PURPOSE
//  Sequences the VGA pattern generators: exactly one pattern receives pattern_enable at a time.
//  Advances to the next pattern on a frame-count timeout (auto mode) or on a user button.
//  Inserts a short blanked interval between patterns.
//  Owns the shared step_size (animation speed), adjusted by speed-up/down buttons.
// PARAMETERS
//  NUM_PATTERNS  4      number of pattern generators scheduled (>=2)
//  HOLD_FRAMES   600    frames a pattern is shown in auto mode (>=2)
//  BLANK_FRAMES  8      frames of blanking between patterns (>=1)
//  STEP_DEFAULT  16     step_size after reset (12-bit, 8.4 fixed point)
//  STEP_INC      4      step_size change per speed button press
//  STEP_MIN      1      lower saturation bound of step_size
// PORTS
//  clk             in   1          pixel clock
//  rst             in   1          asynchronous, active-high reset
//  next_frame      in   1          1-cycle pulse, once per frame (start of vblank)
//  auto_mode       in   1          1 = advance on HOLD_FRAMES timeout
//  btn_next        in   1          synchronized, debounced level; rising edge = advance
//  btn_up          in   1          synchronized level; rising edge = faster
//  btn_down        in   1          synchronized level; rising edge = slower
//  pattern_sel     out  SELW       index of current pattern, SELW=$clog2(NUM_PATTERNS)
//  pattern_enable  out  NUM_PATTERNS  one-hot of pattern_sel; all-zero while blanking
//  blank           out  1          1 = downstream mux forces rgb to 0
//  step_size       out  12         shared animation step for all patterns
// BEHAVIOUR
//  Reset values:
//   - state=SHOW, pattern_sel=0, pattern_enable=1 (bit0), blank=0
//   - step_size=STEP_DEFAULT, hold_cnt=0, blank_cnt=0
//   - button history registers=1, so a button held through reset does not fire
//  Edge detect: press = btn & ~btn_prev. btn_prev is registered every clk.
//  All outputs are registered. Each effect appears the clk after its causing edge.
//  FSM SHOW:
//   - On next_frame: hold_cnt += 1 if auto_mode; hold_cnt holds if auto_mode=0.
//   - Go to BLANK when either of these occurs:
//     (a) btn_next press;
//     (b) auto_mode && next_frame && hold_cnt==HOLD_FRAMES-1.
//   - On entry to BLANK: blank=1, pattern_enable=0, blank_cnt=0.
//     pattern_sel is unchanged at entry.
//  FSM BLANK:
//   - blank_cnt += 1 on each next_frame.
//   - On next_frame with blank_cnt==BLANK_FRAMES-1:
//     - pattern_sel = (pattern_sel==NUM_PATTERNS-1) ? 0 : pattern_sel+1
//     - hold_cnt=0, blank=0, pattern_enable=onehot(new sel), go to SHOW
//   - btn_next presses in BLANK are ignored; they are not queued.
//  Simultaneous (a) and (b): a single advance.
//  auto_mode dropping mid-SHOW: hold_cnt freezes. It resumes counting when auto_mode returns.
//  Speed control:
//   - Operates in both states and is independent of the FSM.
//   - btn_up press: step_size = min(step_size+STEP_INC, 4095). Compute in 13 bits, then saturate.
//   - btn_down press: step_size = max(step_size-STEP_INC, STEP_MIN). No underflow wrap.
//   - btn_up and btn_down pressed in the same cycle: no change.
//  Reset mid-BLANK or mid-SHOW returns immediately (async) to the reset values.
//  pattern_enable is always one-hot or zero. It is never multi-hot.
// TESTING
//  1. Reset release, auto_mode=1, HOLD=4, BLANK=2, 4 next_frame pulses:
//     blank=1, enable=0. After 2 more pulses: sel=1, enable=4'b0010, blank=0.
//  2. Run 3 full cycles past sel=NUM_PATTERNS-1:
//     sel wraps to 0 and enable=4'b0001. No multi-hot observed at any cycle (assertion).
//  3. auto_mode=0, btn_next rising edge in SHOW:
//     blank=1 the next clk. A second press during BLANK gives exactly one advance.
//  4. step_size=4093, btn_up press: step_size=4095.
//     step_size=3, btn_down press: step_size=1.
//     btn_up and btn_down pressed in the same cycle: step_size unchanged.
//  5. btn_next held high across reset release: no advance.
//     Assert rst during BLANK: sel=0, enable=4'b0001, blank=0 immediately.
//  6. auto_mode toggled 1->0->1 mid-hold: total frames shown in SHOW = HOLD_FRAMES of auto time.

Source files
------------

// File: rtl/pattern_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : pattern_scheduler
//  Description : Sequences the VGA pattern generators so that exactly one of
//                them is enabled at a time. It advances on a frame-count
//                timeout (auto mode) or on a user button, and inserts a
//                blanked interval between patterns. It also owns the shared
//                animation step_size, which the speed buttons adjust.
//  Ports       : clk            - pixel clock
//                rst            - asynchronous, active-high reset
//                next_frame     - 1-cycle pulse once per frame
//                auto_mode      - 1 = advance after HOLD_FRAMES frames
//                btn_next       - level; rising edge advances the pattern
//                btn_up         - level; rising edge raises step_size
//                btn_down       - level; rising edge lowers step_size
//                pattern_sel    - index of the current pattern
//                pattern_enable - one-hot of pattern_sel, zero while blanking
//                blank          - 1 = downstream forces rgb to 0
//                step_size      - shared animation step (8.4 fixed point)
//  Revision    : 1.0 - initial release
// ============================================================================
module pattern_scheduler #(
    parameter int NUM_PATTERNS = 4,
    parameter int HOLD_FRAMES  = 600,
    parameter int BLANK_FRAMES = 8,
    parameter int STEP_DEFAULT = 16,
    parameter int STEP_INC     = 4,
    parameter int STEP_MIN     = 1,
    localparam int SELW        = $clog2(NUM_PATTERNS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    next_frame,
    input  logic                    auto_mode,
    input  logic                    btn_next,
    input  logic                    btn_up,
    input  logic                    btn_down,
    output logic [SELW-1:0]         pattern_sel,
    output logic [NUM_PATTERNS-1:0] pattern_enable,
    output logic                    blank,
    output logic [11:0]             step_size
);

    localparam int c_hold_w  = $clog2(HOLD_FRAMES + 1);
    localparam int c_blank_w = $clog2(BLANK_FRAMES + 1);

    localparam logic [c_hold_w-1:0]     c_hold_last  = c_hold_w'(HOLD_FRAMES - 1);
    localparam logic [c_blank_w-1:0]    c_blank_last = c_blank_w'(BLANK_FRAMES - 1);
    localparam logic [SELW-1:0]         c_sel_last   = SELW'(NUM_PATTERNS - 1);
    localparam logic [NUM_PATTERNS-1:0] c_en_first   = NUM_PATTERNS'(1);
    localparam logic [11:0]             c_step_def   = 12'(STEP_DEFAULT);
    localparam logic [11:0]             c_step_min   = 12'(STEP_MIN);
    localparam logic [12:0]             c_step_inc   = 13'(STEP_INC);
    // Below this value a decrement would land under STEP_MIN.
    localparam logic [12:0]             c_step_floor = 13'(STEP_MIN + STEP_INC);

    localparam logic [0:0] c_st_show  = 1'b0;
    localparam logic [0:0] c_st_blank = 1'b1;

    logic [0:0]              r_state;
    logic [SELW-1:0]         r_sel;
    logic [NUM_PATTERNS-1:0] r_enable;
    logic                    r_blank;
    logic [11:0]             r_step;
    logic [c_hold_w-1:0]     r_hold_cnt;
    logic [c_blank_w-1:0]    r_blank_cnt;
    logic                    r_next_prev;
    logic                    r_up_prev;
    logic                    r_down_prev;

    logic                    w_next_press;
    logic                    w_up_press;
    logic                    w_down_press;
    logic                    w_timeout;
    logic [SELW-1:0]         w_sel_adv;
    logic [12:0]             w_step_up;
    logic [12:0]             w_step_dn;
    logic [11:0]             w_step_next;

    assign w_next_press = btn_next & ~r_next_prev;
    assign w_up_press   = btn_up   & ~r_up_prev;
    assign w_down_press = btn_down & ~r_down_prev;
    assign w_timeout    = auto_mode & next_frame & (r_hold_cnt == c_hold_last);
    assign w_sel_adv    = (r_sel == c_sel_last) ? '0 : r_sel + 1'b1;

    // Step arithmetic is done one bit wider so the upward carry is visible
    // for saturation at 4095.
    always_comb begin
        w_step_up   = {1'b0, r_step} + c_step_inc;
        w_step_dn   = {1'b0, r_step} - c_step_inc;
        w_step_next = r_step;
        if (w_up_press && !w_down_press) begin
            w_step_next = w_step_up[12] ? 12'd4095 : w_step_up[11:0];
        end else if (w_down_press && !w_up_press) begin
            w_step_next = ({1'b0, r_step} < c_step_floor) ? c_step_min : w_step_dn[11:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_st_show;
            r_sel       <= '0;
            r_enable    <= c_en_first;
            r_blank     <= 1'b0;
            r_step      <= c_step_def;
            r_hold_cnt  <= '0;
            r_blank_cnt <= '0;
            // History starts high so a button held through reset is not a press.
            r_next_prev <= 1'b1;
            r_up_prev   <= 1'b1;
            r_down_prev <= 1'b1;
        end else begin
            r_next_prev <= btn_next;
            r_up_prev   <= btn_up;
            r_down_prev <= btn_down;
            r_step      <= w_step_next;

            case (r_state)
                c_st_show: begin
                    if (w_next_press || w_timeout) begin
                        r_state     <= c_st_blank;
                        r_blank     <= 1'b1;
                        r_enable    <= '0;
                        r_blank_cnt <= '0;
                    end else if (auto_mode && next_frame) begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                default: begin
                    // btn_next is deliberately not looked at here.
                    if (next_frame) begin
                        if (r_blank_cnt == c_blank_last) begin
                            r_state    <= c_st_show;
                            r_sel      <= w_sel_adv;
                            r_enable   <= c_en_first << w_sel_adv;
                            r_blank    <= 1'b0;
                            r_hold_cnt <= '0;
                        end else begin
                            r_blank_cnt <= r_blank_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign pattern_sel    = r_sel;
    assign pattern_enable = r_enable;
    assign blank          = r_blank;
    assign step_size      = r_step;

endmodule
`default_nettype wire
